// File: rtl/pmem_arbiter_fsm_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pmem_arbiter_fsm_pkg : shared types for the I/D-cache pmem arbiter  |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
package pmem_arbiter_fsm_pkg;

   localparam int C_LINE_W_DEFAULT = 256;

   localparam logic C_GRANT_A = 1'b0;
   localparam logic C_GRANT_B = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SERVE_A = 2'd1,
      ST_SERVE_B = 2'd2,
      ST_DONE    = 2'd3
   } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/pmem_arbiter_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pmem_arbiter_fsm : round-robin arbiter of I/D-cache line requests   |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module pmem_arbiter_fsm
   import pmem_arbiter_fsm_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int LINE_W = C_LINE_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pmem_read_a,
   input  logic [ADDR_W-1:0] pmem_addr_a,
   output logic              pmem_resp_a,
   output logic [LINE_W-1:0] pmem_rdata_a,
   input  logic              pmem_read_b,
   input  logic              pmem_write_b,
   input  logic [ADDR_W-1:0] pmem_addr_b,
   input  logic [LINE_W-1:0] pmem_wdata_b,
   output logic              pmem_resp_b,
   output logic [LINE_W-1:0] pmem_rdata_b,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_address,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic              mem_resp,
   input  logic [LINE_W-1:0] mem_rdata,
   output logic              arb_busy
);

   arb_state_t        r_state;
   arb_state_t        w_state_nxt;
   logic              r_last_grant;
   logic [ADDR_W-1:0] r_hold_addr;
   logic              r_hold_write;
   logic [LINE_W-1:0] r_hold_wdata;

   logic              w_req_a;
   logic              w_req_b;
   logic              w_grant_b;
   logic              w_serving;

   always_comb begin
      w_req_a     = pmem_read_a;
      w_req_b     = pmem_read_b | pmem_write_b;
      // B wins if alone, or on a tie when A held the previous grant
      w_grant_b   = w_req_b & (~w_req_a | (r_last_grant == C_GRANT_A));
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_req_a | w_req_b)
               w_state_nxt = w_grant_b ? ST_SERVE_B : ST_SERVE_A;
         end
         ST_SERVE_A, ST_SERVE_B: begin
            if (mem_resp)
               w_state_nxt = ST_DONE;
         end
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_last_grant <= C_GRANT_B;
         r_hold_addr  <= '0;
         r_hold_write <= 1'b0;
         r_hold_wdata <= '0;
      end else begin
         r_state <= w_state_nxt;
         if ((r_state == ST_IDLE) && (w_req_a | w_req_b)) begin
            r_last_grant <= w_grant_b ? C_GRANT_B : C_GRANT_A;
            r_hold_addr  <= w_grant_b ? pmem_addr_b : pmem_addr_a;
            // simultaneous read+write from B is a writeback
            r_hold_write <= w_grant_b & pmem_write_b;
            r_hold_wdata <= pmem_wdata_b;
         end
      end
   end

   always_comb begin
      w_serving    = (r_state == ST_SERVE_A) || (r_state == ST_SERVE_B);
      mem_read     = w_serving & ~r_hold_write;
      mem_write    = w_serving &  r_hold_write;
      mem_address  = w_serving ? r_hold_addr  : '0;
      mem_wdata    = w_serving ? r_hold_wdata : '0;
      pmem_resp_a  = (r_state == ST_SERVE_A) & mem_resp;
      pmem_resp_b  = (r_state == ST_SERVE_B) & mem_resp;
      pmem_rdata_a = pmem_resp_a ? mem_rdata : '0;
      pmem_rdata_b = pmem_resp_b ? mem_rdata : '0;
      arb_busy     = (r_state != ST_IDLE);
   end

endmodule
`default_nettype wire

// File: tb/tb_pmem_arbiter_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pmem_arbiter_fsm : scoreboard bench for pmem_arbiter_fsm         |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module tb_pmem_arbiter_fsm;

   localparam int ADDR_W = 32;
   localparam int LINE_W = 256;

   logic              clk = 1'b0;
   logic              rst;
   logic              pmem_read_a;
   logic [ADDR_W-1:0] pmem_addr_a;
   logic              pmem_resp_a;
   logic [LINE_W-1:0] pmem_rdata_a;
   logic              pmem_read_b;
   logic              pmem_write_b;
   logic [ADDR_W-1:0] pmem_addr_b;
   logic [LINE_W-1:0] pmem_wdata_b;
   logic              pmem_resp_b;
   logic [LINE_W-1:0] pmem_rdata_b;
   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_address;
   logic [LINE_W-1:0] mem_wdata;
   logic              mem_resp;
   logic [LINE_W-1:0] mem_rdata;
   logic              arb_busy;

   typedef struct {
      bit                port;
      logic [ADDR_W-1:0] addr;
      bit                write;
      logic [LINE_W-1:0] wdata;
      logic [LINE_W-1:0] rdata;
   } exp_t;

   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_err  = 0;
   int   n_resp_a = 0;

   always #5 clk = ~clk;

   pmem_arbiter_fsm #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .pmem_read_a  (pmem_read_a),
      .pmem_addr_a  (pmem_addr_a),
      .pmem_resp_a  (pmem_resp_a),
      .pmem_rdata_a (pmem_rdata_a),
      .pmem_read_b  (pmem_read_b),
      .pmem_write_b (pmem_write_b),
      .pmem_addr_b  (pmem_addr_b),
      .pmem_wdata_b (pmem_wdata_b),
      .pmem_resp_b  (pmem_resp_b),
      .pmem_rdata_b (pmem_rdata_b),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_address  (mem_address),
      .mem_wdata    (mem_wdata),
      .mem_resp     (mem_resp),
      .mem_rdata    (mem_rdata),
      .arb_busy     (arb_busy)
   );

   task automatic check_eq(input string tag, input logic [LINE_W-1:0] act,
                           input logic [LINE_W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic exp_t mk(input bit port, input logic [ADDR_W-1:0] addr,
                               input bit write, input logic [LINE_W-1:0] wdata,
                               input logic [LINE_W-1:0] rdata);
      exp_t e;
      e.port = port; e.addr = addr; e.write = write; e.wdata = wdata; e.rdata = rdata;
      return e;
   endfunction

   // completed memory transactions are matched in grant order
   always @(negedge clk) begin
      if (!rst && (pmem_resp_a || pmem_resp_b || (mem_resp && (mem_read || mem_write)))) begin
         if (pmem_resp_a) n_resp_a++;
         if (sb.size() == 0) begin
            check_eq("sb_unexpected_resp", {255'd0, pmem_resp_a | pmem_resp_b}, '0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check_eq("sb_resp_a", {255'd0, pmem_resp_a}, {255'd0, e.port == 1'b0});
            check_eq("sb_resp_b", {255'd0, pmem_resp_b}, {255'd0, e.port == 1'b1});
            check_eq("sb_rdata_a", pmem_rdata_a, (e.port == 1'b0) ? e.rdata : '0);
            check_eq("sb_rdata_b", pmem_rdata_b, (e.port == 1'b1) ? e.rdata : '0);
            check_eq("sb_addr", {224'd0, mem_address}, {224'd0, e.addr});
            check_eq("sb_write", {255'd0, mem_write}, {255'd0, e.write});
            check_eq("sb_read", {255'd0, mem_read}, {255'd0, !e.write});
            if (e.write) check_eq("sb_wdata", mem_wdata, e.wdata);
         end
      end
   end

   // Waits for the next memory request, answers it after lat cycles with
   // the rdata expected at the scoreboard head; returns at the DONE cycle.
   task automatic serve(input int lat, input bit change_b);
      int n = 0;
      @(negedge clk);
      while (!(mem_read || mem_write) && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!(mem_read || mem_write)) begin
         check_eq("req_seen", {255'd0, mem_read | mem_write}, {255'd0, 1'b1});
         return;
      end
      for (int i = 1; i < lat; i++) begin
         @(posedge clk); #1;
         if (change_b && i == 1) begin
            pmem_addr_b  = 32'h0000_0200;
            pmem_wdata_b = {8{32'hFFFF_0000}};
         end
      end
      mem_resp  = 1'b1;
      mem_rdata = (sb.size() != 0) ? sb[0].rdata : '0;
      @(negedge clk);
      @(posedge clk); #1;
      mem_resp  = 1'b0;
      mem_rdata = '0;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [LINE_W-1:0] r1;
      r1 = {8{32'hA5A5_0001}};

      rst = 1'b1;
      pmem_read_a = 1'b0; pmem_addr_a = '0;
      pmem_read_b = 1'b0; pmem_write_b = 1'b0; pmem_addr_b = '0; pmem_wdata_b = '0;
      mem_resp = 1'b0; mem_rdata = '0;

      @(negedge clk);
      check_eq("rst_busy", {255'd0, arb_busy}, '0);
      check_eq("rst_mem_rd", {255'd0, mem_read | mem_write}, '0);
      check_eq("rst_addr", {224'd0, mem_address}, '0);
      check_eq("rst_resp", {255'd0, pmem_resp_a | pmem_resp_b}, '0);
      @(posedge clk); #1;
      rst = 1'b0;

      // A read only, response after 3 cycles
      idle_cycles(1);
      pmem_read_a = 1'b1; pmem_addr_a = 32'h0000_0040;
      sb.push_back(mk(1'b0, 32'h0000_0040, 1'b0, '0, r1));
      @(negedge clk);
      check_eq("t1_c0_rd", {255'd0, mem_read}, '0);
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("t1_c1_rd", {255'd0, mem_read}, {255'd0, 1'b1});
      check_eq("t1_c1_addr", {224'd0, mem_address}, {224'd0, 32'h0000_0040});
      check_eq("t1_c1_busy", {255'd0, arb_busy}, {255'd0, 1'b1});
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("t1_c2_rd", {255'd0, mem_read}, {255'd0, 1'b1});
      @(posedge clk); #1;
      mem_resp = 1'b1; mem_rdata = r1;
      @(negedge clk);
      check_eq("t1_c3_rd", {255'd0, mem_read}, {255'd0, 1'b1});
      @(posedge clk); #1;
      mem_resp = 1'b0; mem_rdata = '0;
      @(negedge clk);
      check_eq("t1_done_rd", {255'd0, mem_read}, '0);
      check_eq("t1_done_busy", {255'd0, arb_busy}, {255'd0, 1'b1});
      check_eq("t1_done_resp", {255'd0, pmem_resp_a}, '0);
      @(posedge clk); #1;
      pmem_read_a = 1'b0;
      @(negedge clk);
      check_eq("t1_idle_busy", {255'd0, arb_busy}, '0);
      check_eq("t1_resp_count", n_resp_a, 1);

      // tie from reset: A first, then B write, then the next tie goes to B
      @(posedge clk); #1;
      rst = 1'b1;
      pmem_read_a = 1'b1; pmem_addr_a = 32'h0000_1000;
      pmem_write_b = 1'b1; pmem_addr_b = 32'h8000_0000;
      pmem_wdata_b = {8{32'h1234_5678}};
      sb.push_back(mk(1'b0, 32'h0000_1000, 1'b0, '0, {8{32'hB0B0_0002}}));
      sb.push_back(mk(1'b1, 32'h8000_0000, 1'b1, {8{32'h1234_5678}}, {8{32'hC0C0_0003}}));
      idle_cycles(2);
      rst = 1'b0;
      serve(2, 1'b0);
      pmem_addr_a = 32'h0000_2000;
      sb.push_back(mk(1'b0, 32'h0000_2000, 1'b0, '0, {8{32'hD0D0_0004}}));
      serve(1, 1'b0);
      pmem_write_b = 1'b0;
      serve(2, 1'b0);
      pmem_read_a = 1'b0;
      idle_cycles(2);

      // B address changed while being served
      pmem_read_b = 1'b1; pmem_addr_b = 32'h0000_0100;
      sb.push_back(mk(1'b1, 32'h0000_0100, 1'b0, '0, {8{32'hE0E0_0005}}));
      serve(3, 1'b1);
      pmem_read_b = 1'b0;
      idle_cycles(2);

      // reset two cycles into SERVE_A, late mem_resp
      pmem_read_a = 1'b1; pmem_addr_a = 32'h0000_0300;
      @(posedge clk);
      @(posedge clk);
      #3;
      check_eq("t4_pre_rd", {255'd0, mem_read}, {255'd0, 1'b1});
      #1 rst = 1'b1;
      #1;
      check_eq("t4_async_rd", {255'd0, mem_read | mem_write}, '0);
      check_eq("t4_async_busy", {255'd0, arb_busy}, '0);
      pmem_read_a = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0; mem_resp = 1'b1; mem_rdata = {8{32'hBAD0_0006}};
      @(negedge clk);
      check_eq("t4_late_resp_a", {255'd0, pmem_resp_a}, '0);
      check_eq("t4_late_rdata_a", pmem_rdata_a, '0);
      @(posedge clk); #1;
      mem_resp = 1'b0; mem_rdata = '0;
      idle_cycles(1);

      // B read and write together is a write
      pmem_read_b = 1'b1; pmem_write_b = 1'b1; pmem_addr_b = 32'h0000_0400;
      pmem_wdata_b = {8{32'h0F0F_7777}};
      sb.push_back(mk(1'b1, 32'h0000_0400, 1'b1, {8{32'h0F0F_7777}}, {8{32'h5555_0007}}));
      serve(2, 1'b0);
      pmem_read_b = 1'b0; pmem_write_b = 1'b0;
      idle_cycles(2);

      // stray mem_resp in IDLE
      mem_resp = 1'b1; mem_rdata = {8{32'hDEAD_BEEF}};
      @(negedge clk);
      check_eq("t5_idle_resp", {255'd0, pmem_resp_a | pmem_resp_b}, '0);
      check_eq("t5_idle_rdata", pmem_rdata_a | pmem_rdata_b, '0);
      @(posedge clk); #1;
      mem_resp = 1'b0; mem_rdata = '0;
      idle_cycles(2);

      check_eq("sb_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
